// File: rtl/multicycle_datapath_if.sv
// rtl/multicycle_datapath_if.sv - shared instruction/data memory port with req/ready handshake
interface multicycle_datapath_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
      input  mem_rdata, mem_ready
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/multicycle_datapath.sv
// rtl/multicycle_datapath.sv - multi-cycle RV32I/RV32E datapath, FETCH/DECODE/EXEC/MEM/WB sequencer
module multicycle_datapath #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          NREGS    = 32
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [1:0]                   ResultSrc,
   input  logic                         PCSrc,
   input  logic                         Jalr,
   input  logic                         ALUSrc,
   input  logic                         RegWrite,
   input  logic                         MemWrite,
   input  logic                         Op5,
   input  logic [1:0]                   ImmSrc,
   input  logic [1:0]                   Store,
   input  logic [2:0]                   Load,
   input  logic [3:0]                   ALUControl,
   output logic [31:0]                  Instr,
   output logic                         Zero,
   output logic                         ALUR0,
   output logic [31:0]                  PC,
   multicycle_datapath_if.master        mem,
   output logic                         retire,
   output logic                         halted
);
   localparam int IW = (NREGS == 16) ? 4 : 5;

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_ir;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [31:0] r_alu_out;
   logic [31:0] r_mdr;
   logic [31:0] r_next_pc;
   logic        r_retire;
   logic        r_halted;
   logic [31:0] r_rf [0:NREGS-1];

   logic [IW-1:0] w_rs1, w_rs2, w_rd;
   logic [31:0]   w_rd1, w_rd2;
   logic [31:0]   w_imm, w_src_b, w_alu;
   logic [31:0]   w_pc_plus4, w_pc_imm, w_upper, w_urd, w_result;
   logic [31:0]   w_maddr, w_lshift, w_load;
   logic [1:0]    w_size;
   logic          w_misaligned, w_fetch_ok, w_req, w_we;

   assign w_rs1 = r_ir[15 +: IW];
   assign w_rs2 = r_ir[20 +: IW];
   assign w_rd  = r_ir[7 +: IW];
   assign w_rd1 = (w_rs1 == '0) ? 32'b0 : r_rf[w_rs1];
   assign w_rd2 = (w_rs2 == '0) ? 32'b0 : r_rf[w_rs2];

   always_comb begin
      w_imm = 32'b0;
      case (ImmSrc)
         2'b00: w_imm = {{20{r_ir[31]}}, r_ir[31:20]};
         2'b01: w_imm = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
         2'b10: w_imm = {{20{r_ir[31]}}, r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
         default: w_imm = {{12{r_ir[31]}}, r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
      endcase
   end

   assign w_src_b = ALUSrc ? w_imm : r_b;

   always_comb begin
      w_alu = w_src_b;
      case (ALUControl)
         4'b0000: w_alu = r_a + w_src_b;
         4'b0001: w_alu = r_a - w_src_b;
         4'b0010: w_alu = r_a & w_src_b;
         4'b0011: w_alu = r_a | w_src_b;
         4'b0100: w_alu = r_a ^ w_src_b;
         4'b0101: w_alu = {31'b0, $signed(r_a) < $signed(w_src_b)};
         4'b0110: w_alu = {31'b0, r_a < w_src_b};
         4'b0111: w_alu = r_a << w_src_b[4:0];
         4'b1000: w_alu = r_a >> w_src_b[4:0];
         4'b1001: w_alu = $signed(r_a) >>> w_src_b[4:0];
         default: w_alu = w_src_b;
      endcase
   end

   assign Zero  = (w_alu == 32'b0);
   assign ALUR0 = w_alu[0];

   assign w_pc_plus4 = r_pc + 32'd4;
   assign w_pc_imm   = r_pc + w_imm;
   assign w_upper    = {r_ir[31:12], 12'b0};
   assign w_urd      = Op5 ? w_upper : (r_pc + w_upper);

   // Access size comes from the store encoding for stores and the low load bits otherwise
   assign w_maddr      = r_alu_out;
   assign w_size       = MemWrite ? Store : Load[1:0];
   assign w_misaligned = ((w_size == 2'b01) && w_maddr[0]) ||
                         ((w_size == 2'b10) && (w_maddr[1:0] != 2'b00));
   assign w_fetch_ok   = (r_pc[1:0] == 2'b00);
   assign w_req = reset && (((r_state == S_FETCH) && w_fetch_ok) ||
                            ((r_state == S_MEM) && !w_misaligned));
   assign w_we  = w_req && (r_state == S_MEM) && MemWrite;

   assign mem.mem_req  = w_req;
   assign mem.mem_we   = w_we;
   assign mem.mem_addr = (r_state == S_MEM) ? w_maddr : r_pc;

   always_comb begin
      mem.mem_wdata = r_b;
      mem.mem_wstrb = 4'b0000;
      case (Store)
         2'b00:   mem.mem_wdata = {4{r_b[7:0]}};
         2'b01:   mem.mem_wdata = {2{r_b[15:0]}};
         default: mem.mem_wdata = r_b;
      endcase
      if (w_we) begin
         case (Store)
            2'b00:   mem.mem_wstrb = 4'b0001 << w_maddr[1:0];
            2'b01:   mem.mem_wstrb = 4'b0011 << w_maddr[1:0];
            default: mem.mem_wstrb = 4'b1111;
         endcase
      end
   end

   assign w_lshift = mem.mem_rdata >> {w_maddr[1:0], 3'b000};

   always_comb begin
      w_load = w_lshift;
      case (Load)
         3'b000:  w_load = {{24{w_lshift[7]}}, w_lshift[7:0]};
         3'b001:  w_load = {{16{w_lshift[15]}}, w_lshift[15:0]};
         3'b100:  w_load = {24'b0, w_lshift[7:0]};
         3'b101:  w_load = {16'b0, w_lshift[15:0]};
         default: w_load = w_lshift;
      endcase
   end

   always_comb begin
      w_result = r_alu_out;
      case (ResultSrc)
         2'b00:   w_result = r_alu_out;
         2'b01:   w_result = r_mdr;
         2'b10:   w_result = w_pc_plus4;
         default: w_result = w_urd;
      endcase
   end

   // Register file is deliberately left out of reset; x0 is handled on the read side
   always_ff @(posedge clk) begin
      if (reset && (r_state == S_WB) && RegWrite && (w_rd != '0))
         r_rf[w_rd] <= w_result;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_FETCH;
         r_pc      <= RESET_PC;
         r_ir      <= 32'h0000_0013;
         r_a       <= 32'b0;
         r_b       <= 32'b0;
         r_alu_out <= 32'b0;
         r_mdr     <= 32'b0;
         r_next_pc <= RESET_PC;
         r_retire  <= 1'b0;
         r_halted  <= 1'b0;
      end else begin
         r_retire <= 1'b0;
         case (r_state)
            S_FETCH: begin
               if (!w_fetch_ok) begin
                  r_state  <= S_HALT;
                  r_halted <= 1'b1;
               end else if (mem.mem_ready) begin
                  r_ir    <= mem.mem_rdata;
                  r_state <= S_DECODE;
               end
            end
            S_DECODE: begin
               r_a     <= w_rd1;
               r_b     <= w_rd2;
               r_state <= S_EXEC;
            end
            S_EXEC: begin
               r_alu_out <= w_alu;
               if (Jalr)
                  r_next_pc <= {w_alu[31:1], 1'b0};
               else if (PCSrc)
                  r_next_pc <= w_pc_imm;
               else
                  r_next_pc <= w_pc_plus4;
               if ((ResultSrc == 2'b01) || MemWrite) begin
                  r_state <= S_MEM;
               end else begin
                  r_state  <= S_WB;
                  r_retire <= 1'b1;
               end
            end
            S_MEM: begin
               if (w_misaligned) begin
                  r_state  <= S_HALT;
                  r_halted <= 1'b1;
               end else if (mem.mem_ready) begin
                  if (!MemWrite)
                     r_mdr <= w_load;
                  r_state  <= S_WB;
                  r_retire <= 1'b1;
               end
            end
            S_WB: begin
               r_pc    <= r_next_pc;
               r_state <= S_FETCH;
            end
            S_HALT: r_halted <= 1'b1;
            default: r_state <= S_FETCH;
         endcase
      end
   end

   assign Instr  = r_ir;
   assign PC     = r_pc;
   assign retire = r_retire;
   assign halted = r_halted;
endmodule
